// File: rtl/ascon_dec_stream_io.sv
// Streaming load/unload wrapper around the masked ASCON decryption core.
// Loads NS-share secrets plus randomness W bits per beat, launches the core once,
// then streams plaintext and tag W bits per beat.
// Optional feature macro: ASCON_DEC_TAG_CHECK_EN adds exptag_in and gates the
// plaintext on a tag comparison; when undefined tag_ok is tied high.
module ascon_dec_stream_io #(
   parameter int unsigned K  = 128,
   parameter int unsigned L  = 80,
   parameter int unsigned Y  = 80,
   parameter int unsigned W  = 8,
   parameter int unsigned NS = 3,
   parameter int unsigned NR = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [NS*W-1:0]   key_in,
   input  logic [NS*W-1:0]   nonce_in,
   input  logic [NS*W-1:0]   ad_in,
   input  logic [NS*W-1:0]   ct_in,
   input  logic [NR*W-1:0]   rnd_in,
   input  logic [2*W-1:0]    flt_in,
`ifdef ASCON_DEC_TAG_CHECK_EN
   input  logic [W-1:0]      exptag_in,
`endif
   input  logic              start,
   output logic              core_start,
   output logic [NS*K-1:0]   core_key,
   output logic [NS*128-1:0] core_nonce,
   output logic [NS*L-1:0]   core_ad,
   output logic [NS*Y-1:0]   core_ct,
   output logic [NR*64-1:0]  core_rnd,
   output logic [127:0]      core_flt128,
   output logic [Y-1:0]      core_flty,
   input  logic              core_done,
   input  logic [Y-1:0]      core_pt,
   input  logic [127:0]      core_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      pt_out,
   output logic [W-1:0]      tag_out,
   output logic              busy,
   output logic              done,
   output logic              tag_ok
);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned MaxIn = max2(max2(max2(K, 128), max2(L, Y)), 64);
   localparam int unsigned NIN   = MaxIn / W;
   localparam int unsigned NOUT  = max2(Y, 128) / W;
   localparam int unsigned CntW  = $clog2(NIN + 1);

   typedef enum logic [1:0] {StLoad, StArmed, StRun, StUnload} state_e;

   state_e state_q, state_d;

   logic [CntW-1:0] in_cnt_q, out_cnt_q;
   logic [31:0]     filled;

   logic [K-1:0]    key_q   [NS];
   logic [127:0]    nonce_q [NS];
   logic [L-1:0]    ad_q    [NS];
   logic [Y-1:0]    ct_q    [NS];
   logic [63:0]     rnd_q   [NR];
   logic [127:0]    flt128_q;
   logic [Y-1:0]    flty_q;
   logic [Y-1:0]    pt_q;
   logic [127:0]    tag_q;

   logic core_start_q, done_q, tag_ok_q, tag_match;
   logic load_beat, last_in, launch, capture, out_fire, last_out;

`ifdef ASCON_DEC_TAG_CHECK_EN
   logic [127:0] exptag_q;
   assign tag_match = (core_tag == exptag_q);
`else
   assign tag_match = 1'b1;
`endif

   // Bits already loaded into every field before the current beat.
   assign filled = 32'(in_cnt_q) * W;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StLoad;
      else     state_q <= state_d;
   end

   // Next-state decode and per-cycle event strobes.
   always_comb begin
      state_d   = state_q;
      load_beat = 1'b0;
      last_in   = 1'b0;
      launch    = 1'b0;
      capture   = 1'b0;
      out_fire  = 1'b0;
      last_out  = 1'b0;
      case (state_q)
         StLoad: begin
            if (in_valid) begin
               load_beat = 1'b1;
               if (in_cnt_q == CntW'(NIN - 1)) begin
                  last_in = 1'b1;
                  state_d = StArmed;
               end
            end
         end
         StArmed: begin
            if (start) begin
               launch  = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            if (core_done) begin
               capture = 1'b1;
               state_d = StUnload;
            end
         end
         StUnload: begin
            if (out_ready) begin
               out_fire = 1'b1;
               if (out_cnt_q == CntW'(NOUT - 1)) begin
                  last_out = 1'b1;
                  state_d  = StLoad;
               end
            end
         end
         default: state_d = StLoad;
      endcase
   end

   // Beat counters for the load and unload phases.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         if (last_in)        in_cnt_q <= '0;
         else if (load_beat) in_cnt_q <= in_cnt_q + 1'b1;
         if (last_out)       out_cnt_q <= '0;
         else if (out_fire)  out_cnt_q <= out_cnt_q + 1'b1;
      end
   end

   // Shift-in of secret shares; a field stops shifting once full so the first beat
   // lands in its MSBs. Everything is wiped on reset and after the final output beat.
   always_ff @(posedge clk) begin
      if (rst || last_out) begin
         key_q   <= '{default: '0};
         nonce_q <= '{default: '0};
         ad_q    <= '{default: '0};
         ct_q    <= '{default: '0};
      end else if (load_beat) begin
         for (int s = 0; s < int'(NS); s++) begin
            if (filled < K)   key_q[s]   <= (key_q[s] << W)   | K'(key_in[s*W +: W]);
            if (filled < 128) nonce_q[s] <= (nonce_q[s] << W) | 128'(nonce_in[s*W +: W]);
            if (filled < L)   ad_q[s]    <= (ad_q[s] << W)    | L'(ad_in[s*W +: W]);
            if (filled < Y)   ct_q[s]    <= (ct_q[s] << W)    | Y'(ct_in[s*W +: W]);
         end
      end
   end

   // Shift-in of per-run randomness, same fill rule as the secret fields.
   always_ff @(posedge clk) begin
      if (rst || last_out) begin
         rnd_q    <= '{default: '0};
         flt128_q <= '0;
         flty_q   <= '0;
      end else if (load_beat) begin
         for (int n = 0; n < int'(NR); n++) begin
            if (filled < 64) rnd_q[n] <= (rnd_q[n] << W) | 64'(rnd_in[n*W +: W]);
         end
         if (filled < 128) flt128_q <= (flt128_q << W) | 128'(flt_in[W-1:0]);
         if (filled < Y)   flty_q   <= (flty_q << W)   | Y'(flt_in[2*W-1:W]);
      end
   end

`ifdef ASCON_DEC_TAG_CHECK_EN
   // Expected tag is loaded like any other 128-bit field.
   always_ff @(posedge clk) begin
      if (rst || last_out)                  exptag_q <= '0;
      else if (load_beat && (filled < 128)) exptag_q <= (exptag_q << W) | 128'(exptag_in);
   end

   // Tag verdict lives from capture until the next accepted load beat.
   always_ff @(posedge clk) begin
      if (rst || load_beat) tag_ok_q <= 1'b0;
      else if (capture)     tag_ok_q <= tag_match;
   end
`else
   // Without tag checking the verdict is always positive.
   always_ff @(posedge clk) begin
      tag_ok_q <= 1'b1;
   end
`endif

   // Capture of core results; plaintext withheld on a tag mismatch.
   always_ff @(posedge clk) begin
      if (rst || last_out) begin
         pt_q  <= '0;
         tag_q <= '0;
      end else if (capture) begin
         pt_q  <= tag_match ? core_pt : '0;
         tag_q <= core_tag;
      end
   end

   // Registered one-cycle launch and completion pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         core_start_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         core_start_q <= launch;
         done_q       <= last_out;
      end
   end

   // Flatten share/randomness registers onto the core buses.
   always_comb begin
      core_key    = '0;
      core_nonce  = '0;
      core_ad     = '0;
      core_ct     = '0;
      core_rnd    = '0;
      for (int s = 0; s < int'(NS); s++) begin
         core_key[s*K +: K]       = key_q[s];
         core_nonce[s*128 +: 128] = nonce_q[s];
         core_ad[s*L +: L]        = ad_q[s];
         core_ct[s*Y +: Y]        = ct_q[s];
      end
      for (int n = 0; n < int'(NR); n++) begin
         core_rnd[n*64 +: 64] = rnd_q[n];
      end
      core_flt128 = flt128_q;
      core_flty   = flty_q;
   end

   // Handshake/status outputs and output slice selection (LSB slice first; slices
   // past the end of a field read as zero because the shift runs off the top).
   always_comb begin
      in_ready   = (state_q == StLoad);
      out_valid  = (state_q == StUnload);
      busy       = (state_q != StLoad);
      core_start = core_start_q;
      done       = done_q;
      tag_ok     = tag_ok_q;
      pt_out     = '0;
      tag_out    = '0;
      if (state_q == StUnload) begin
         pt_out  = W'(pt_q >> (32'(out_cnt_q) * W));
         tag_out = W'(tag_q >> (32'(out_cnt_q) * W));
      end
   end

endmodule

// File: tb/tb_ascon_dec_stream_io.sv
// Directed bench for ascon_dec_stream_io with default parameters.
// Covers reset, load fill rule, start gating, result capture, stalled unload and
// abort by reset; also exercises ASCON_DEC_TAG_CHECK_EN when that macro is defined.
module tb_ascon_dec_stream_io;

   localparam int unsigned K  = 128;
   localparam int unsigned L  = 80;
   localparam int unsigned Y  = 80;
   localparam int unsigned W  = 8;
   localparam int unsigned NS = 3;
   localparam int unsigned NR = 7;
`ifdef ASCON_DEC_TAG_CHECK_EN
   localparam bit TagChk = 1'b1;
`else
   localparam bit TagChk = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst, in_valid, in_ready, start, core_start, core_done;
   logic              out_valid, out_ready, busy, done, tag_ok;
   logic [NS*W-1:0]   key_in, nonce_in, ad_in, ct_in;
   logic [NR*W-1:0]   rnd_in;
   logic [2*W-1:0]    flt_in;
   logic [NS*K-1:0]   core_key;
   logic [NS*128-1:0] core_nonce;
   logic [NS*L-1:0]   core_ad;
   logic [NS*Y-1:0]   core_ct;
   logic [NR*64-1:0]  core_rnd;
   logic [127:0]      core_flt128, core_tag;
   logic [Y-1:0]      core_flty, core_pt;
   logic [W-1:0]      pt_out, tag_out;
`ifdef ASCON_DEC_TAG_CHECK_EN
   logic [W-1:0]      exptag_in;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int start_pulses = 0;

   logic [7:0] exp_pt [16] = '{8'h0A, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03,
                               8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

   ascon_dec_stream_io #(.K(K), .L(L), .Y(Y), .W(W), .NS(NS), .NR(NR)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .key_in      (key_in),
      .nonce_in    (nonce_in),
      .ad_in       (ad_in),
      .ct_in       (ct_in),
      .rnd_in      (rnd_in),
      .flt_in      (flt_in),
`ifdef ASCON_DEC_TAG_CHECK_EN
      .exptag_in   (exptag_in),
`endif
      .start       (start),
      .core_start  (core_start),
      .core_key    (core_key),
      .core_nonce  (core_nonce),
      .core_ad     (core_ad),
      .core_ct     (core_ct),
      .core_rnd    (core_rnd),
      .core_flt128 (core_flt128),
      .core_flty   (core_flty),
      .core_done   (core_done),
      .core_pt     (core_pt),
      .core_tag    (core_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .pt_out      (pt_out),
      .tag_out     (tag_out),
      .busy        (busy),
      .done        (done),
      .tag_ok      (tag_ok)
   );

   always #5 clk = ~clk;

   // Count launch pulses seen by the core.
   always @(posedge clk) begin
      if (core_start) start_pulses <= start_pulses + 1;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // 16 load beats with one idle cycle after beat 7; optional start pulse on beat 5.
   task automatic load_all(input bit start_at5);
      for (int j = 0; j < 16; j++) begin
         key_in   = {8'(j + 32), 8'(j + 16), 8'(j)};
         nonce_in = {3{8'(j + 8'hB0)}};
         ad_in    = {3{8'(j + 8'hA0)}};
         ct_in    = {3{8'(j + 8'hC0)}};
         rnd_in   = {7{8'(j + 8'h40)}};
         flt_in   = {8'(j + 8'h60), 8'(j + 8'h50)};
`ifdef ASCON_DEC_TAG_CHECK_EN
         exptag_in = 8'(j + 8'h70);
`endif
         start    = start_at5 && (j == 5);
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         start    = 1'b0;
         if (j == 7) tick();
      end
   endtask

   // Launch, let the core answer after two cycles, then land in UNLOAD.
   task automatic run_core();
      start = 1'b1;
      tick();
      check("core_start_pulse", core_start, 1);
      tick();
      start = 1'b0;
      check("core_start_single", core_start, 0);
      tick();
      core_pt   = 80'h0102030405060708090A;
      core_tag  = 128'h0F0E0D0C0B0A09080706050403020100;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      core_pt   = '0;
      core_tag  = '0;
      check("unload_valid", out_valid, 1);
      check("unload_tag_ok", tag_ok, !TagChk);
   endtask

   // Drain all output beats; stall 3 cycles when beat stall_at is presented.
   task automatic unload(input int stall_at);
      int j = 0;
      int stalls = 0;
      int guard = 0;
      while (j < 16 && guard < 100) begin
         if (j == stall_at && stalls < 3) begin
            out_ready = 1'b0;
            stalls++;
            check($sformatf("hold_pt[%0d]", j), pt_out, TagChk ? 8'h00 : exp_pt[j]);
            check($sformatf("hold_tag[%0d]", j), tag_out, 8'(j));
         end else begin
            out_ready = 1'b1;
            check($sformatf("valid[%0d]", j), out_valid, 1);
            check($sformatf("pt[%0d]", j), pt_out, TagChk ? 8'h00 : exp_pt[j]);
            check($sformatf("tag[%0d]", j), tag_out, 8'(j));
            j++;
         end
         tick();
         guard++;
      end
      out_ready = 1'b0;
      check("beat_count", j, 16);
      check("done_pulse", done, 1);
      check("valid_after", out_valid, 0);
      check("key_cleared", core_key, 0);
      check("rnd_cleared", core_rnd, 0);
      tick();
      check("done_single", done, 0);
      check("ready_after", in_ready, 1);
   endtask

   initial begin
      int p;
      rst = 1'b1; in_valid = 1'b0; start = 1'b0; core_done = 1'b0; out_ready = 1'b0;
      key_in = '0; nonce_in = '0; ad_in = '0; ct_in = '0; rnd_in = '0; flt_in = '0;
      core_pt = '0; core_tag = '0;
`ifdef ASCON_DEC_TAG_CHECK_EN
      exptag_in = '0;
`endif
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_core_start", core_start, 0);
      check("rst_done", done, 0);
      check("rst_tag_ok", tag_ok, !TagChk);
      check("rst_core_key", core_key, 0);

      // Load with a start pulse during LOAD that must be forgotten.
      load_all(1'b1);
      check("key_s0", core_key[127:0], 128'h000102030405060708090A0B0C0D0E0F);
      check("key_s1", core_key[255:128], 128'h101112131415161718191A1B1C1D1E1F);
      check("key_s2", core_key[383:256], 128'h202122232425262728292A2B2C2D2E2F);
      check("nonce_s0", core_nonce[127:0], 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF);
      check("ad_s0", core_ad[79:0], 80'hA0A1A2A3A4A5A6A7A8A9);
      check("ct_s2", core_ct[239:160], 80'hC0C1C2C3C4C5C6C7C8C9);
      check("rnd_0", core_rnd[63:0], 64'h4041424344454647);
      check("rnd_6", core_rnd[447:384], 64'h4041424344454647);
      check("flt128", core_flt128, 128'h505152535455565758595A5B5C5D5E5F);
      check("flty", core_flty, 80'h60616263646566676869);

      // ARMED: no launch without start, input beats ignored.
      check("armed_busy", busy, 1);
      check("armed_in_ready", in_ready, 0);
      key_in   = '1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("armed_no_start", start_pulses, 0);
      check("armed_key_hold", core_key[127:0], 128'h000102030405060708090A0B0C0D0E0F);
      check("armed_stays", busy, 1);

      run_core();
      check("launch_count", start_pulses, 1);
      unload(4);

      // Abort by reset while the core is running.
      load_all(1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      p = start_pulses;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_core_start", core_start, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_key", core_key, 0);
      check("abort_pt", pt_out, 0);
      check("abort_tag", tag_out, 0);
      check("abort_done", done, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("abort_no_launch", start_pulses, p);
      check("abort_in_ready", in_ready, 1);

      // Fresh full load, then an unstalled run.
      load_all(1'b0);
      check("reload_key_s0", core_key[127:0], 128'h000102030405060708090A0B0C0D0E0F);
      run_core();
      check("launch_count2", start_pulses, p + 1);
      unload(-1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
